mux_2a1_rr: RTL and testbench
=============================

Name: mux_2a1_rr

Overview:
- 2:1 interleaving multiplexer; the inverse of the team's 1:2 alternating demux.
- Two 8-bit valid-qualified lanes are buffered in small per-lane FIFOs.
- Words are recombined onto one output stream in strict alternation: lane 0, lane 1, lane 0, and so on. This restores the original word order split by the demux.
- Sits at the receive end of the split path, feeding the single-lane consumer. The consumer applies backpressure through out_ready.

Parameters:
- DATA_WIDTH, 8, width of every data word.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in0  input  DATA_WIDTH  lane 0 data.
- valid_in0  input  1  lane 0 word present this cycle.
- data_in1  input  DATA_WIDTH  lane 1 data.
- valid_in1  input  1  lane 1 word present this cycle.
- full0  output  1  lane 0 FIFO full; combinational from the occupancy count.
- full1  output  1  lane 1 FIFO full.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  DATA_WIDTH  registered output word.
- valid_out  output  1  registered; data_out is meaningful.
- err_overflow  output  1  sticky; set when a word arrives at a full lane.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - selector=0, both FIFO counts and pointers = 0.
  - data_out=0, valid_out=0, err_overflow=0, full0=full1=0.
  - Reset mid-operation flushes all buffered words; nothing is emitted after release.
- Lane write, for each lane X:
  - When valid_inX=1 and fullX=0, data_inX is pushed at the rising edge.
  - When valid_inX=1 and fullX=1, the word is dropped and err_overflow is set to 1. It stays 1 until reset.
  - full is computed from the count at the start of the cycle. A pop in the same cycle does not free space for that cycle's write.
- Output stage load condition: load = (valid_out==0) or (out_ready==1).
- Pop and selector:
  - If load=1 and FIFO[selector] is non-empty: pop its head into data_out, set valid_out=1, toggle selector.
  - If load=1 and FIFO[selector] is empty: valid_out goes 0, data_out holds its previous value, selector does not toggle.
  - The other lane is never popped out of turn, even if non-empty (strict alternation preserves order).
  - If load=0 (stall): data_out, valid_out and selector hold, and no pop occurs.
- Latency: a word pushed at edge k into an empty, selected lane, with the output free, is on data_out with valid_out=1 after edge k+1.
- Throughput: one word per cycle when both lanes keep up and out_ready stays 1.
- Simultaneous push and pop on the same non-empty lane is allowed; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Counts range 0..FIFO_DEPTH (width clog2(FIFO_DEPTH)+1).
- No state machine beyond the 1-bit selector and the FIFO counters.

Decomposition:
- Shared package (mux_demux_pkg):
  - DATA_WIDTH default.
  - Lane index constants LANE0=0, LANE1=1 (also used by demux).
  - FIFO_DEPTH default.
- One natural sub-module: fifo_lane.
  - Synchronous FIFO with push, pop, data_in, data_out (head, combinational), empty, full and count.
  - Same clock and asynchronous active-low reset.
  - Instantiated twice.
- The selector and output register stay in mux_2a1_rr.

Test Plan:
- Reset, then idle: hold reset_L=0 for 2 cycles -> valid_out=0, data_out=0x00, full0=full1=0, err_overflow=0; release with no input -> valid_out stays 0.
- Ordered interleave, out_ready=1:
  - Stimulus: lane 0 gets 0x10,0x12,0x14 and lane 1 gets 0x11,0x13,0x15, one word each per cycle on both lanes.
  - Required: data_out sequence 0x10,0x11,0x12,0x13,0x14,0x15, first word one edge after its push.
- Starved turn: push 0xA0,0xA2 on lane 0 only -> 0xA0 emitted, then valid_out=0 while selector=1. Later push 0xA1 on lane 1 -> 0xA1 then 0xA2 emitted in order.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while feeding both lanes.
  - Required: data_out/valid_out hold their first value; lanes fill to 4 and full0=full1=1. Releasing out_ready drains all 8 words in alternating order.
- Overflow: with lane 0 full and out_ready=0, push 0xEE -> 0xEE is never emitted, err_overflow=1 and stays 1 after the drain.
- Reset mid-stream: assert reset_L=0 with 3 words buffered -> outputs clear immediately without waiting for clk. After release, the next pushed word 0x55 on lane 0 is the first output.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// Shared definitions for the alternating 1:2 demux / 2:1 mux pair on the split data path.
// Lane numbering must agree on both ends, otherwise the restored word order breaks.
package mux_demux_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int NUM_LANES      = 2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Occupancy counters need one extra bit to represent "completely full".
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mux_2a1_rr_if.sv
// Bundle of the two ingress lanes and the single backpressured egress stream of mux_2a1_rr.
interface mux_2a1_rr_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  valid_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  valid_in1;
  logic                  full0;
  logic                  full1;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  err_overflow;

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1, out_ready,
    input  full0, full1, data_out, valid_out, err_overflow
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1, out_ready,
    output full0, full1, data_out, valid_out, err_overflow
  );
endinterface

// File: rtl/mux_2a1_rr_fifo_lane.sv
// Small per-lane synchronous FIFO with a combinational head; a push into a full FIFO
// or a pop from an empty one is ignored.
module fifo_lane
  import mux_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset_L,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               empty,
  output logic                               full,
  output logic [count_width(FIFO_DEPTH)-1:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign count    = count_reg;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr_reg];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= data_in;
  end

endmodule

// File: rtl/mux_2a1_rr.sv
// 2:1 interleaving mux: recombines two buffered lanes in strict lane0/lane1 alternation,
// undoing the alternating split, into one registered, backpressured output stream.
module mux_2a1_rr
  import mux_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset_L,
  mux_2a1_rr_if.slave  bus
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] lane_data  [NUM_LANES];
  logic [DATA_WIDTH-1:0] lane_head  [NUM_LANES];
  logic [CW-1:0]         lane_count [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_valid;
  logic [NUM_LANES-1:0]  lane_push;
  logic [NUM_LANES-1:0]  lane_pop;
  logic [NUM_LANES-1:0]  lane_empty;
  logic [NUM_LANES-1:0]  lane_fifo_full;
  logic [NUM_LANES-1:0]  lane_full;
  logic [NUM_LANES-1:0]  lane_ovf;

  logic                  sel_reg, sel_next;
  logic                  valid_out_reg, valid_out_next;
  logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
  logic                  err_reg, err_next;
  logic                  load;

  assign lane_data[LANE0]  = bus.data_in0;
  assign lane_data[LANE1]  = bus.data_in1;
  assign lane_valid[LANE0] = bus.valid_in0;
  assign lane_valid[LANE1] = bus.valid_in1;

  assign load = ~valid_out_reg | bus.out_ready;

  // full reflects the count at the start of the cycle; a same-cycle pop never frees room.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_full[gi] = (lane_count[gi] == CW'(FIFO_DEPTH));
    assign lane_push[gi] = lane_valid[gi] & ~lane_fifo_full[gi];
    assign lane_ovf[gi]  = lane_valid[gi] & lane_full[gi];
    assign lane_pop[gi]  = load & (sel_reg == 1'(gi)) & ~lane_empty[gi];

    fifo_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_L  (reset_L),
      .push     (lane_push[gi]),
      .pop      (lane_pop[gi]),
      .data_in  (lane_data[gi]),
      .data_out (lane_head[gi]),
      .empty    (lane_empty[gi]),
      .full     (lane_fifo_full[gi]),
      .count    (lane_count[gi])
    );
  end

  // Only the selected lane may be popped; an empty turn waits rather than skipping ahead.
  always_comb begin
    sel_next       = sel_reg;
    valid_out_next = valid_out_reg;
    data_out_next  = data_out_reg;
    err_next       = err_reg | (|lane_ovf);
    if (load) begin
      if (!lane_empty[sel_reg]) begin
        data_out_next  = lane_head[sel_reg];
        valid_out_next = 1'b1;
        sel_next       = ~sel_reg;
      end else begin
        valid_out_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_reg       <= LANE0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      sel_reg       <= sel_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      err_reg       <= err_next;
    end
  end

  assign bus.full0        = lane_full[LANE0];
  assign bus.full1        = lane_full[LANE1];
  assign bus.data_out     = data_out_reg;
  assign bus.valid_out    = valid_out_reg;
  assign bus.err_overflow = err_reg;

endmodule

// File: tb/tb_mux_2a1_rr.sv
// Directed bench for mux_2a1_rr: interleave order, starved turns, backpressure, overflow
// and asynchronous reset, each output checked against hand-computed values.
module tb_mux_2a1_rr;

  logic clk;
  logic reset_L;
  int   checks_cnt;
  int   errors_cnt;

  mux_2a1_rr_if #(.DATA_WIDTH(8)) bus_if ();

  mux_2a1_rr #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle just after it.
  task automatic step(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic rdy);
    bus_if.valid_in0 = v0;
    bus_if.data_in0  = d0;
    bus_if.valid_in1 = v1;
    bus_if.data_in1  = d1;
    bus_if.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d);
    check_val({tag, ".valid"}, 32'(bus_if.valid_out), 32'd1);
    check_val({tag, ".data"},  32'(bus_if.data_out),  32'(d));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset_L    = 1'b0;
    bus_if.valid_in0 = 1'b0; bus_if.data_in0 = 8'h00;
    bus_if.valid_in1 = 1'b0; bus_if.data_in1 = 8'h00;
    bus_if.out_ready = 1'b1;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.valid", 32'(bus_if.valid_out), 32'd0);
    check_val("rst.data",  32'(bus_if.data_out),  32'h00);
    check_val("rst.full0", 32'(bus_if.full0),     32'd0);
    check_val("rst.full1", 32'(bus_if.full1),     32'd0);
    check_val("rst.err",   32'(bus_if.err_overflow), 32'd0);
    reset_L = 1'b1;
    idle(1'b1);
    idle(1'b1);
    check_val("idle.valid", 32'(bus_if.valid_out), 32'd0);

    // Ordered interleave: first word one edge after its push
    step(1'b1, 8'h10, 1'b1, 8'h11, 1'b1);
    check_val("ilv.first_empty", 32'(bus_if.valid_out), 32'd0);
    step(1'b1, 8'h12, 1'b1, 8'h13, 1'b1); expect_word("ilv0", 8'h10);
    step(1'b1, 8'h14, 1'b1, 8'h15, 1'b1); expect_word("ilv1", 8'h11);
    idle(1'b1); expect_word("ilv2", 8'h12);
    idle(1'b1); expect_word("ilv3", 8'h13);
    idle(1'b1); expect_word("ilv4", 8'h14);
    idle(1'b1); expect_word("ilv5", 8'h15);
    idle(1'b1);
    check_val("ilv.done", 32'(bus_if.valid_out), 32'd0);

    // Starved turn: lane 1 empty must stall even though lane 0 holds 0xA2
    step(1'b1, 8'hA0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 8'h00, 1'b1); expect_word("stv0", 8'hA0);
    idle(1'b1);
    check_val("stv.wait_valid", 32'(bus_if.valid_out), 32'd0);
    check_val("stv.wait_hold",  32'(bus_if.data_out),  32'hA0);
    idle(1'b1);
    check_val("stv.wait2_valid", 32'(bus_if.valid_out), 32'd0);
    step(1'b0, 8'h00, 1'b1, 8'hA1, 1'b1);
    check_val("stv.push1_valid", 32'(bus_if.valid_out), 32'd0);
    idle(1'b1); expect_word("stv1", 8'hA1);
    idle(1'b1); expect_word("stv2", 8'hA2);
    step(1'b0, 8'h00, 1'b1, 8'hA3, 1'b1);
    idle(1'b1); expect_word("stv3", 8'hA3);
    idle(1'b1);
    check_val("stv.done", 32'(bus_if.valid_out), 32'd0);

    // Backpressure: out_ready low for 5 cycles while both lanes fill
    step(1'b1, 8'hB0, 1'b1, 8'hB1, 1'b0);
    check_val("bp.c1_valid", 32'(bus_if.valid_out), 32'd0);
    step(1'b1, 8'hB2, 1'b1, 8'hB3, 1'b0); expect_word("bp.c2", 8'hB0);
    step(1'b1, 8'hB4, 1'b1, 8'hB5, 1'b0); expect_word("bp.c3", 8'hB0);
    step(1'b1, 8'hB6, 1'b1, 8'hB7, 1'b0);
    check_val("bp.c4_full1", 32'(bus_if.full1), 32'd1);
    check_val("bp.c4_full0", 32'(bus_if.full0), 32'd0);
    step(1'b1, 8'hB8, 1'b0, 8'h00, 1'b0); expect_word("bp.c5", 8'hB0);
    check_val("bp.full0", 32'(bus_if.full0), 32'd1);
    check_val("bp.full1", 32'(bus_if.full1), 32'd1);
    check_val("bp.err_before", 32'(bus_if.err_overflow), 32'd0);

    // Overflow: word at a full lane is dropped and flags sticky error
    step(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
    check_val("ovf.err", 32'(bus_if.err_overflow), 32'd1);
    expect_word("ovf.hold", 8'hB0);

    // Drain in alternating order, 0xEE never appears
    idle(1'b1); expect_word("drn1", 8'hB1);
    check_val("drn.full1_free", 32'(bus_if.full1), 32'd0);
    idle(1'b1); expect_word("drn2", 8'hB2);
    idle(1'b1); expect_word("drn3", 8'hB3);
    idle(1'b1); expect_word("drn4", 8'hB4);
    idle(1'b1); expect_word("drn5", 8'hB5);
    idle(1'b1); expect_word("drn6", 8'hB6);
    idle(1'b1); expect_word("drn7", 8'hB7);
    idle(1'b1); expect_word("drn8", 8'hB8);
    idle(1'b1);
    check_val("drn.done", 32'(bus_if.valid_out), 32'd0);
    check_val("drn.err_sticky", 32'(bus_if.err_overflow), 32'd1);

    // Reset mid-stream with three words buffered (selector is on lane 1 here)
    step(1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 8'h00, 1'b0); expect_word("mid.out", 8'hC1);
    step(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
    reset_L = 1'b0;
    #1;
    check_val("arst.valid", 32'(bus_if.valid_out), 32'd0);
    check_val("arst.data",  32'(bus_if.data_out),  32'h00);
    check_val("arst.full0", 32'(bus_if.full0),     32'd0);
    check_val("arst.err",   32'(bus_if.err_overflow), 32'd0);
    idle(1'b1);
    idle(1'b1);
    reset_L = 1'b1;
    idle(1'b1);
    idle(1'b1);
    check_val("post.flushed", 32'(bus_if.valid_out), 32'd0);
    step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    check_val("post.push_valid", 32'(bus_if.valid_out), 32'd0);
    idle(1'b1); expect_word("post.first", 8'h55);
    idle(1'b1);
    check_val("post.done", 32'(bus_if.valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
